// File: rtl/freq_meter_if.sv
// -----------------------------------------------------------------------------
// freq_meter_if
// Groups the measured input and the measurement/status outputs of freq_meter.
//   master : the meter side  (receives I_SIG, drives the O_* results)
//   slave  : the user side   (drives I_SIG, observes the O_* results)
// Signals:
//   I_SIG      measured square wave, asynchronous to the meter clock
//   O_PERIOD   last measured period in clock cycles (CNT_W bits)
//   O_VALID    one-cycle pulse when O_PERIOD updates
//   O_MODE     locked rate: 1 = 1 Hz, 0 = 2 Hz
//   O_LOCK     rate classification is stable
//   O_TIMEOUT  input lost; sticky until the next rising edge
// -----------------------------------------------------------------------------
interface freq_meter_if #(
    parameter int unsigned CNT_W = 27
);
    logic             I_SIG;
    logic [CNT_W-1:0] O_PERIOD;
    logic             O_VALID;
    logic             O_MODE;
    logic             O_LOCK;
    logic             O_TIMEOUT;

    modport master (
        input  I_SIG,
        output O_PERIOD,
        output O_VALID,
        output O_MODE,
        output O_LOCK,
        output O_TIMEOUT
    );

    modport slave (
        output I_SIG,
        input  O_PERIOD,
        input  O_VALID,
        input  O_MODE,
        input  O_LOCK,
        input  O_TIMEOUT
    );
endinterface

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
// Measures the period of a slow square wave (I_SIG, asynchronous) in I_CLK
// cycles between successive rising edges, classifies each period as the
// divider's 1 Hz or 2 Hz rate, and reports lock once two consecutive periods
// agree. Loss of input is flagged after TIMEOUT cycles without an edge.
// Ports:
//   I_CLK    system clock
//   I_RST_N  asynchronous active-low reset
//   bus      freq_meter_if.master: I_SIG in; O_PERIOD, O_VALID, O_MODE,
//            O_LOCK, O_TIMEOUT out (all outputs registered)
// -----------------------------------------------------------------------------
module freq_meter #(
    parameter int unsigned CNT_W      = 27,
    parameter int unsigned PERIOD_1HZ = 50_000_000,
    parameter int unsigned PERIOD_2HZ = 25_000_000,
    parameter int unsigned TOL        = 500_000,
    parameter int unsigned TIMEOUT    = 75_000_000
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    freq_meter_if.master  bus
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_1HZ  = 2'd1,
        CLS_2HZ  = 2'd2
    } cls_e;

    // Comparison constants carry one extra bit so |P - nominal| never wraps.
    localparam logic [CNT_W:0]   NOM_1HZ_C  = PERIOD_1HZ[CNT_W:0];
    localparam logic [CNT_W:0]   NOM_2HZ_C  = PERIOD_2HZ[CNT_W:0];
    localparam logic [CNT_W:0]   TOL_C      = TOL[CNT_W:0];
    localparam int unsigned      TO_LAST_I  = TIMEOUT - 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST_C = TO_LAST_I[CNT_W-1:0];

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a,
                                                input logic [CNT_W:0] b);
        logic [CNT_W:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

    // 1 Hz is tested first, so it wins if the two tolerance windows overlap.
    function automatic cls_e classify(input logic [CNT_W:0] p);
        cls_e c;
        if (abs_diff(p, NOM_1HZ_C) <= TOL_C) begin
            c = CLS_1HZ;
        end else if (abs_diff(p, NOM_2HZ_C) <= TOL_C) begin
            c = CLS_2HZ;
        end else begin
            c = CLS_NONE;
        end
        return c;
    endfunction

    logic             sync1_q, sync2_q, prev_q;
    logic             edge_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             mode_q, mode_d;
    logic             lock_q, lock_d;
    logic             timeout_q, timeout_d;
    cls_e             cand_q, cand_d;
    logic [1:0]       match_q, match_d;
    logic [CNT_W:0]   p_ext_s;
    cls_e             cls_s;

    // Edge detect: a rise that has passed both synchroniser stages.
    assign edge_s  = sync2_q & ~prev_q;
    // Period of the edge being captured this cycle (counter started at 0).
    assign p_ext_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cls_s   = classify(p_ext_s);

    // Synchroniser and previous-value flop; reset high so a level held
    // across reset release never looks like a rising edge.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= bus.I_SIG;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Measurement state, result and lock registers.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            period_q  <= {CNT_W{1'b0}};
            valid_q   <= 1'b0;
            mode_q    <= 1'b0;
            lock_q    <= 1'b0;
            timeout_q <= 1'b0;
            cand_q    <= CLS_NONE;
            match_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            mode_q    <= mode_d;
            lock_q    <= lock_d;
            timeout_q <= timeout_d;
            cand_q    <= cand_d;
            match_q   <= match_d;
        end
    end

    // Next-state logic: counting, capture, classification/lock and timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        mode_d    = mode_q;
        lock_d    = lock_q;
        timeout_d = timeout_q;
        cand_d    = cand_q;
        match_d   = match_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                // Arming edge: starts a measurement but has no period yet.
                if (edge_s) begin
                    timeout_d = 1'b0;
                    state_d   = ST_MEASURE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_MEASURE: begin
                // An edge on the timeout cycle is still a valid capture.
                if (edge_s) begin
                    period_d = p_ext_s[CNT_W-1:0];
                    valid_d  = 1'b1;
                    cnt_d    = {CNT_W{1'b0}};
                    if (cls_s == CLS_NONE) begin
                        lock_d  = 1'b0;
                        match_d = 2'd0;
                    end else if (cls_s == cand_q) begin
                        // Saturating match count; lock from the second match.
                        if (match_q >= 2'd1) begin
                            match_d = 2'd2;
                            lock_d  = 1'b1;
                            mode_d  = (cand_q == CLS_1HZ);
                        end else begin
                            match_d = 2'd1;
                        end
                    end else begin
                        cand_d  = cls_s;
                        match_d = 2'd1;
                        lock_d  = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST_C) begin
                    timeout_d = 1'b1;
                    lock_d    = 1'b0;
                    match_d   = 2'd0;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign bus.O_PERIOD  = period_q;
    assign bus.O_VALID   = valid_q;
    assign bus.O_MODE    = mode_q;
    assign bus.O_LOCK    = lock_q;
    assign bus.O_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
// Drives I_SIG with rises at known cycle numbers; a behavioural model turns
// the gaps between rises into expected (period, lock, mode) entries on a
// queue, which are popped and compared whenever the meter pulses O_VALID.
// -----------------------------------------------------------------------------
module tb_freq_meter;

    localparam int CNT_W   = 8;
    localparam int P1      = 100;
    localparam int P2      = 50;
    localparam int TOLV    = 5;
    localparam int TIMEOUT = 150;

    localparam int CLS_N = 0;
    localparam int CLS_A = 1;
    localparam int CLS_B = 2;

    typedef struct {
        int   per;
        logic lock;
        logic mode;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_valid = 0;
    int   last_valid_cyc = 0;
    int   to_cyc = -1;
    logic to_prev = 1'b0;
    exp_t sb_q[$];

    // Behavioural model state
    logic m_armed = 1'b0;
    int   m_cand  = CLS_N;
    int   m_cnt   = 0;
    logic m_lock  = 1'b0;
    logic m_mode  = 1'b0;
    int   m_last  = 0;

    freq_meter_if #(.CNT_W(CNT_W)) bus ();

    freq_meter #(
        .CNT_W      (CNT_W),
        .PERIOD_1HZ (P1),
        .PERIOD_2HZ (P2),
        .TOL        (TOLV),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .I_CLK   (clk),
        .I_RST_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_armed = 1'b0;
        m_cand  = CLS_N;
        m_cnt   = 0;
        m_lock  = 1'b0;
        m_mode  = 1'b0;
    endtask

    // Called at every driven rise of I_SIG.
    task automatic model_rise();
        int   gap = cyc - m_last;
        int   cls;
        exp_t e;
        m_last = cyc;
        if (m_armed && gap > TIMEOUT) begin
            m_armed = 1'b0;
            m_lock  = 1'b0;
            m_cnt   = 0;
        end
        if (!m_armed) begin
            m_armed = 1'b1;
            return;
        end
        if (absi(gap - P1) <= TOLV)      cls = CLS_A;
        else if (absi(gap - P2) <= TOLV) cls = CLS_B;
        else                             cls = CLS_N;
        if (cls == CLS_N) begin
            m_lock = 1'b0;
            m_cnt  = 0;
        end else if (cls == m_cand) begin
            if (m_cnt < 2) m_cnt++;
            if (m_cnt == 2) begin
                m_lock = 1'b1;
                m_mode = (m_cand == CLS_A);
            end
        end else begin
            m_cand = cls;
            m_cnt  = 1;
            m_lock = 1'b0;
        end
        e.per  = gap;
        e.lock = m_lock;
        e.mode = m_mode;
        sb_q.push_back(e);
    endtask

    // One period of p cycles starting with a rise, 50% duty.
    task automatic send_period(input int p);
        @(negedge clk);
        bus.I_SIG = 1'b1;
        model_rise();
        repeat (p / 2) @(negedge clk);
        bus.I_SIG = 1'b0;
        repeat (p - p / 2 - 1) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_period"},  int'(bus.O_PERIOD),  0);
        check({tag, "_valid"},   int'(bus.O_VALID),   0);
        check({tag, "_mode"},    int'(bus.O_MODE),    0);
        check({tag, "_lock"},    int'(bus.O_LOCK),    0);
        check({tag, "_timeout"}, int'(bus.O_TIMEOUT), 0);
    endtask

    // Scoreboard consumer and timeout-edge tracker.
    always @(negedge clk) begin
        if (bus.O_VALID) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_period", int'(bus.O_PERIOD), e.per);
                check("sb_lock",   int'(bus.O_LOCK),   int'(e.lock));
                check("sb_mode",   int'(bus.O_MODE),   int'(e.mode));
            end
        end
        if (bus.O_TIMEOUT && !to_prev) to_cyc = cyc;
        to_prev = bus.O_TIMEOUT;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int w;
        bus.I_SIG = 1'b0;
        rst_n     = 1'b0;
        repeat (5) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);

        // 1: steady 1 Hz; lock on the second matching capture
        repeat (3) send_period(100);
        check("t1_lock", int'(bus.O_LOCK), 1);
        check("t1_mode", int'(bus.O_MODE), 1);

        // 2: switch to 2 Hz
        repeat (3) send_period(50);
        check("t2_lock",   int'(bus.O_LOCK),   1);
        check("t2_mode",   int'(bus.O_MODE),   0);
        check("t2_period", int'(bus.O_PERIOD), 50);

        // 3: tolerance edges, out-of-tolerance, and the timeout-cycle capture
        send_period(104);
        send_period(96);
        check("t3_relock_lock", int'(bus.O_LOCK), 0);
        send_period(105);
        check("t3_lock", int'(bus.O_LOCK), 1);
        check("t3_mode", int'(bus.O_MODE), 1);
        send_period(106);
        send_period(150);
        check("t3_106_period", int'(bus.O_PERIOD), 106);
        check("t3_106_lock",   int'(bus.O_LOCK),   0);
        check("t3_106_mode",   int'(bus.O_MODE),   1);
        send_period(100);
        check("t3_150_period", int'(bus.O_PERIOD), 150);
        check("t3_150_to",     int'(bus.O_TIMEOUT), 0);

        // 4: relock, then lose the input
        repeat (2) send_period(100);
        check("t4_lock_before", int'(bus.O_LOCK), 1);
        w = 0;
        while (!bus.O_TIMEOUT && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("t4_timeout_seen", int'(bus.O_TIMEOUT), 1);
        check("t4_timeout_delay", to_cyc - last_valid_cyc, 150);
        check("t4_lock",   int'(bus.O_LOCK),   0);
        check("t4_mode",   int'(bus.O_MODE),   1);
        check("t4_period", int'(bus.O_PERIOD), 100);
        n0 = n_valid;
        send_period(100);
        check("t4_timeout_clear", int'(bus.O_TIMEOUT), 0);
        check("t4_arm_no_valid", n_valid, n0);
        send_period(100);
        check("t4_after_period", int'(bus.O_PERIOD), 100);
        check("t4_after_valid", n_valid, n0 + 1);

        // 5: input held high through reset release
        @(negedge clk);
        bus.I_SIG = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        n0 = n_valid;
        repeat (200) @(negedge clk);
        check("t5_no_valid", n_valid, n0);
        check("t5_no_timeout", int'(bus.O_TIMEOUT), 0);
        bus.I_SIG = 1'b0;
        repeat (10) @(negedge clk);
        repeat (3) send_period(100);
        check("t5_valids", n_valid, n0 + 2);
        check("t5_lock", int'(bus.O_LOCK), 1);

        // 6: one-cycle async reset mid-period while locked
        @(negedge clk);
        bus.I_SIG = 1'b1;
        model_rise();
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (20) @(negedge clk);
        bus.I_SIG = 1'b0;
        repeat (30) @(negedge clk);
        repeat (2) send_period(100);
        check("t6_first_lock", int'(bus.O_LOCK), 0);
        send_period(100);
        check("t6_relock", int'(bus.O_LOCK), 1);
        check("t6_mode",   int'(bus.O_MODE), 1);

        repeat (20) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
